// File: rtl/mul32_mac_ctrl.sv
// Multiply-accumulate controller around an external combinational 32x32->64 multiplier.
// Operands are registered onto mul_op1/op2; the product is sampled MUL_LAT cycles later and summed.
module mul32_mac_ctrl #(
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic              in_last,
  input  logic              acc_clr,
  output logic [31:0]       mul_op1,
  output logic [31:0]       mul_op2,
  input  logic [63:0]       mul_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  localparam int WW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

  state_t           state, state_nx;
  logic [63:0]      acc, prod;
  logic [CNT_W-1:0] cnt;
  logic             ovf, last;
  logic [WW-1:0]    wcnt;
  logic [64:0]      sum;
  logic             accept;

  assign sum    = {1'b0, acc} + {1'b0, prod};
  // in_ready is held low while reset is asserted so every output reads 0 during reset
  assign in_ready = rst_n & (state == IDLE) & ~acc_clr;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = MUL;
      MUL:  if (wcnt == '0) state_nx = ACC;
      ACC:  state_nx = last ? OUT : IDLE;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_op1 <= '0;
      mul_op2 <= '0;
      acc     <= '0;
      prod    <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      last    <= 1'b0;
      wcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (accept) begin
            mul_op1 <= in_a;
            mul_op2 <= in_b;
            last    <= in_last;
            wcnt    <= WW'(MUL_LAT - 1);
          end
        end
        MUL: begin
          if (wcnt != '0) wcnt <= wcnt - WW'(1);
          else            prod <= mul_res;
        end
        ACC: begin
          acc <= sum[63:0];
          ovf <= ovf | sum[64];
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
        end
        OUT: begin
          if (out_ready) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_acc = acc;
  assign out_cnt = cnt;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_mul32_mac_ctrl.sv
// Directed bench: table of operand pairs with hand-computed sums, plus hand sequences
// for backpressure, acc_clr and mid-wait reset (second instance with MUL_LAT=3).
module tb_mul32_mac_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance 1: MUL_LAT=1
  logic        rst_n, in_valid, in_ready, in_last, acc_clr, out_valid, out_ready, out_ovf;
  logic [31:0] in_a, in_b, mul_op1, mul_op2;
  logic [63:0] mul_res, out_acc;
  logic [15:0] out_cnt;

  // instance 2: MUL_LAT=3
  logic        rst2_n, v2, rdy2, l2, clr2, ov2, ordy2, ovf2;
  logic [31:0] a2, b2, op1_2, op2_2;
  logic [63:0] res2, acc2;
  logic [15:0] cnt2;

  // behavioural Mul32
  assign mul_res = {32'b0, mul_op1} * {32'b0, mul_op2};
  assign res2    = {32'b0, op1_2} * {32'b0, op2_2};

  mul32_mac_ctrl #(.MUL_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .acc_clr(acc_clr),
    .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_res(mul_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  mul32_mac_ctrl #(.MUL_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst2_n), .in_valid(v2), .in_ready(rdy2),
    .in_a(a2), .in_b(b2), .in_last(l2), .acc_clr(clr2),
    .mul_op1(op1_2), .mul_op2(op2_2), .mul_res(res2),
    .out_valid(ov2), .out_ready(ordy2),
    .out_acc(acc2), .out_cnt(cnt2), .out_ovf(ovf2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // present a pair, hold until accepted; w = cycles spent waiting for in_ready
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last, output int w);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1; w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) chk("accept_timeout", 64'(w), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mul_op1", 64'(mul_op1), 64'(a));
    chk("mul_op2", 64'(mul_op2), 64'(b));
    chk("in_ready_busy", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 50);
    if (!out_valid) chk("out_timeout", 64'(n), 64'd2);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        last;
    logic [63:0] acc;
    logic [15:0] cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl[5];
  int   w, n;

  initial begin
    tbl[0] = '{32'h9,        32'h7,        1'b1, 64'h3F,                  16'd1, 1'b0};
    tbl[1] = '{32'h9,        32'h7,        1'b0, 64'h0,                   16'd0, 1'b0};
    tbl[2] = '{32'h3,        32'h5,        1'b1, 64'h4E,                  16'd2, 1'b0};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h0,                   16'd0, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFC00000002,    16'd2, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    acc_clr = 1'b0; out_ready = 1'b1;
    rst2_n = 1'b0; v2 = 1'b0; a2 = '0; b2 = '0; l2 = 1'b0; clr2 = 1'b0; ordy2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_op1", 64'(mul_op1), 64'd0);
    chk("rst_acc", out_acc, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // table: single term, two terms back-to-back, overflow
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].last, w);
      if (i > 0 && !tbl[i-1].last) chk("b2b_wait", 64'(w), 64'd2);
      if (tbl[i].last) begin
        wait_out(n);
        chk("latency", 64'(n), 64'd2);
        chk("out_acc", out_acc, tbl[i].acc);
        chk("out_cnt", 64'(out_cnt), 64'(tbl[i].cnt));
        chk("out_ovf", 64'(out_ovf), 64'(tbl[i].ovf));
        @(posedge clk); #1;
        chk("out_pulse", 64'(out_valid), 64'd0);
        chk("acc_cleared", out_acc, 64'd0);
        chk("ovf_cleared", 64'(out_ovf), 64'd0);
      end
    end

    // backpressure
    out_ready = 1'b0;
    send(32'h2, 32'h3, 1'b1, w);
    wait_out(n);
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_acc", out_acc, 64'h6);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      if (k < 3) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done_valid", 64'(out_valid), 64'd0);
    chk("bp_done_acc", out_acc, 64'd0);
    chk("bp_done_ready", 64'(in_ready), 64'd1);

    // acc_clr in IDLE blocks acceptance and wipes the partial sum
    send(32'h9, 32'h7, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("clr_pre_acc", out_acc, 64'h3F);
    acc_clr = 1'b1; in_valid = 1'b1; in_a = 32'h55; in_b = 32'h66; in_last = 1'b1;
    #1;
    chk("clr_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    acc_clr = 1'b0; in_valid = 1'b0;
    chk("clr_acc", out_acc, 64'd0);
    chk("clr_cnt", 64'(out_cnt), 64'd0);
    chk("clr_op1_held", 64'(mul_op1), 64'h9);
    send(32'h2, 32'h2, 1'b1, w);
    wait_out(n);
    chk("clr_out_acc", out_acc, 64'h4);
    chk("clr_out_cnt", 64'(out_cnt), 64'd1);
    @(posedge clk); #1;

    // reset during the MUL wait on the MUL_LAT=3 instance
    a2 = 32'h5; b2 = 32'h6; l2 = 1'b1; v2 = 1'b1;
    #1;
    chk("d3_ready", 64'(rdy2), 64'd1);
    @(posedge clk); #1;
    v2 = 1'b0;
    chk("d3_op1", 64'(op1_2), 64'h5);
    @(posedge clk); #1;
    rst2_n = 1'b0;
    #1;
    chk("d3_rst_op1", 64'(op1_2), 64'd0);
    chk("d3_rst_op2", 64'(op2_2), 64'd0);
    chk("d3_rst_valid", 64'(ov2), 64'd0);
    chk("d3_rst_acc", acc2, 64'd0);
    chk("d3_rst_ready", 64'(rdy2), 64'd0);
    @(negedge clk);
    rst2_n = 1'b1;
    #1;
    chk("d3_rel_ready", 64'(rdy2), 64'd1);
    a2 = 32'h1; b2 = 32'h1; l2 = 1'b1; v2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ov2 && n < 50);
    chk("d3_latency", 64'(n), 64'd4);
    chk("d3_acc", acc2, 64'h1);
    chk("d3_cnt", 64'(cnt2), 64'd1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
